// File: rtl/xup_vector_op_sequencer_if.sv
// Bus between the requesters, the sequencer and the shared bitwise unit.
// The sequencer side is the slave; the requester/unit side is the master.
interface xup_vector_op_sequencer_if #(
  parameter int SIZE = 8,
  parameter int NREQ = 4
);
  logic [NREQ-1:0]           req;
  logic [NREQ-1:0][SIZE-1:0] a_bus;
  logic [NREQ-1:0][SIZE-1:0] b_bus;
  logic [NREQ-1:0]           gnt;
  logic [NREQ-1:0]           done;
  logic [SIZE-1:0]           y_out;
  logic                      busy;
  logic [SIZE-1:0]           unit_a;
  logic [SIZE-1:0]           unit_b;
  logic [SIZE-1:0]           unit_y;

  modport slave (
    input  req, a_bus, b_bus, unit_y,
    output gnt, done, y_out, busy, unit_a, unit_b
  );

  modport master (
    output req, a_bus, b_bus, unit_y,
    input  gnt, done, y_out, busy, unit_a, unit_b
  );
endinterface

// File: rtl/xup_vector_op_sequencer.sv
// Round-robin sequencer sharing one combinational bitwise unit among NREQ
// requesters. Operands are registered at grant, held for SETTLE cycles so the
// gate-level unit can settle, then the result is captured and returned with a
// one-cycle done pulse to the granted requester.
module xup_vector_op_sequencer #(
  parameter int SIZE   = 8,
  parameter int NREQ   = 4,
  parameter int SETTLE = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  xup_vector_op_sequencer_if.slave   bus
);

  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW0 = $clog2(SETTLE + 1);
  localparam int CW  = (CW0 < 1) ? 1 : CW0;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [SIZE-1:0] y_q, y_d;
  logic [SIZE-1:0] ua_q, ua_d;
  logic [SIZE-1:0] ub_q, ub_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [IW-1:0]   g_q, g_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [IW-1:0]   pick;
  logic            pick_vld;
  int              idx;

  // Round-robin pick: first set req bit at or above the pointer, wrapping.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!pick_vld && bus.req[idx]) begin
        pick_vld = 1'b1;
        pick     = IW'(idx);
      end
    end
  end

  // Next-state and next-register values; everything holds unless changed.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    y_d     = y_q;
    ua_d    = ua_q;
    ub_d    = ub_q;
    rr_d    = rr_q;
    g_d     = g_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          ua_d        = bus.a_bus[pick];
          ub_d        = bus.b_bus[pick];
          g_d         = pick;
          cnt_d       = '0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        // Operands have been stable for SETTLE cycles at the terminal count.
        if (cnt_q == CW'(SETTLE - 1)) begin
          y_d         = bus.unit_y;
          done_d[g_q] = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        gnt_d   = '0;
        // Served requester drops to lowest priority for the next pick.
        rr_d    = (g_q == IW'(NREQ - 1)) ? '0 : g_q + IW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset wins over any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      y_q     <= '0;
      ua_q    <= '0;
      ub_q    <= '0;
      rr_q    <= '0;
      g_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      y_q     <= y_d;
      ua_q    <= ua_d;
      ub_q    <= ub_d;
      rr_q    <= rr_d;
      g_q     <= g_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.done   = done_q;
  assign bus.y_out  = y_q;
  assign bus.busy   = (state_q != IDLE);
  assign bus.unit_a = ua_q;
  assign bus.unit_b = ub_q;

endmodule

// File: tb/tb_xup_vector_op_sequencer.sv
// Directed bench: SETTLE=2 main instance plus SETTLE=1 and SETTLE=4 builds,
// each driving a behavioural AND unit with 3ns gate delay.
module tb_xup_vector_op_sequencer;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  xup_vector_op_sequencer_if #(.SIZE(8), .NREQ(4)) i2 ();
  xup_vector_op_sequencer_if #(.SIZE(8), .NREQ(4)) i1 ();
  xup_vector_op_sequencer_if #(.SIZE(8), .NREQ(4)) i4 ();

  xup_vector_op_sequencer #(.SIZE(8), .NREQ(4), .SETTLE(2)) dut2 (
    .clk(clk), .reset(reset), .bus(i2.slave));
  xup_vector_op_sequencer #(.SIZE(8), .NREQ(4), .SETTLE(1)) dut1 (
    .clk(clk), .reset(reset), .bus(i1.slave));
  xup_vector_op_sequencer #(.SIZE(8), .NREQ(4), .SETTLE(4)) dut4 (
    .clk(clk), .reset(reset), .bus(i4.slave));

  // Shared gate-level unit models
  assign #3 i2.unit_y = i2.unit_a & i2.unit_b;
  assign #3 i1.unit_y = i1.unit_a & i1.unit_b;
  assign #3 i4.unit_y = i4.unit_a & i4.unit_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  logic [7:0] exp_y [4];
  int         idx;

  initial begin
    exp_y = '{8'h0F, 8'h88, 8'h18, 8'h81};
    reset = 1'b1;
    i2.req = '0; i2.a_bus = '0; i2.b_bus = '0;
    i1.req = '0; i1.a_bus = '0; i1.b_bus = '0;
    i4.req = '0; i4.a_bus = '0; i4.b_bus = '0;

    // Reset state
    tick(); tick();
    check("rst_gnt",    i2.gnt,    0);
    check("rst_done",   i2.done,   0);
    check("rst_y",      i2.y_out,  0);
    check("rst_busy",   i2.busy,   0);
    check("rst_unit_a", i2.unit_a, 0);
    check("rst_unit_b", i2.unit_b, 0);

    // Single request: F0 & 3C = 30
    reset = 1'b0;
    i2.a_bus[0] = 8'hF0; i2.b_bus[0] = 8'h3C; i2.req = 4'b0001;
    tick();
    check("single_gnt",    i2.gnt,    4'b0001);
    check("single_busy",   i2.busy,   1);
    check("single_unit_a", i2.unit_a, 8'hF0);
    check("single_unit_b", i2.unit_b, 8'h3C);
    tick();
    check("single_done_early", i2.done, 0);
    tick();
    check("single_done", i2.done,  4'b0001);
    check("single_y",    i2.y_out, 8'h30);
    i2.req = '0;
    tick();
    check("single_idle_busy", i2.busy,  0);
    check("single_idle_gnt",  i2.gnt,   0);
    check("single_idle_done", i2.done,  0);
    check("single_y_held",    i2.y_out, 8'h30);

    // All requests: order 0,1,2,3,0, one grant every 4 cycles
    reset = 1'b1; tick(); reset = 1'b0;
    i2.a_bus[0] = 8'hFF; i2.b_bus[0] = 8'h0F;
    i2.a_bus[1] = 8'hAA; i2.b_bus[1] = 8'hCC;
    i2.a_bus[2] = 8'h5A; i2.b_bus[2] = 8'h3C;
    i2.a_bus[3] = 8'h81; i2.b_bus[3] = 8'hFF;
    i2.req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      idx = k % 4;
      check($sformatf("all_gnt%0d", k), i2.gnt, 32'd1 << idx);
      tick(); tick();
      check($sformatf("all_done%0d", k), i2.done, 32'd1 << idx);
      check($sformatf("all_y%0d", k), i2.y_out, exp_y[idx]);
      tick();
      check($sformatf("all_gap_gnt%0d", k), i2.gnt, 0);
      check($sformatf("all_gap_busy%0d", k), i2.busy, 0);
      tick();
    end

    // Fairness: req=0011 alternates 0,1,0,1
    reset = 1'b1; tick(); reset = 1'b0;
    i2.req = 4'b0011;
    tick();
    for (int k = 0; k < 4; k++) begin
      idx = k % 2;
      check($sformatf("fair_gnt%0d", k), i2.gnt, 32'd1 << idx);
      tick(); tick();
      check($sformatf("fair_done%0d", k), i2.done, 32'd1 << idx);
      tick(); tick();
    end

    // Operand change and req drop during WAIT: AA & 0F = 0A
    reset = 1'b1; tick(); reset = 1'b0;
    i2.a_bus[1] = 8'hAA; i2.b_bus[1] = 8'h0F; i2.req = 4'b0010;
    tick();
    check("chg_gnt", i2.gnt, 4'b0010);
    i2.a_bus[1] = 8'h00; i2.req = '0;
    tick(); tick();
    check("chg_done", i2.done,  4'b0010);
    check("chg_y",    i2.y_out, 8'h0A);
    tick();
    check("chg_idle", i2.busy, 0);

    // Reset mid-WAIT
    i2.a_bus[2] = 8'hFF; i2.b_bus[2] = 8'h55; i2.req = 4'b0100;
    tick();
    check("midrst_gnt_before", i2.gnt, 4'b0100);
    reset = 1'b1;
    tick();
    check("midrst_gnt",  i2.gnt,   0);
    check("midrst_done", i2.done,  0);
    check("midrst_y",    i2.y_out, 0);
    check("midrst_busy", i2.busy,  0);
    reset = 1'b0;
    tick();
    check("post_rst_gnt2", i2.gnt, 4'b0100);
    tick(); tick();
    check("post_rst_done2", i2.done,  4'b0100);
    check("post_rst_y2",    i2.y_out, 8'h55);
    // Pointer now 3; a reset must return it to 0 so slot 0 wins over slot 3
    i2.req = 4'b1001;
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    tick();
    check("rr_rst_gnt0", i2.gnt, 4'b0001);
    tick(); tick(); tick(); tick();
    check("rr_rst_gnt3", i2.gnt, 4'b1000);
    i2.req = '0;

    // SETTLE=1 and SETTLE=4 builds
    i1.a_bus[0] = 8'hC3; i1.b_bus[0] = 8'h5A; i1.req = 4'b0001;
    i4.a_bus[1] = 8'h3C; i4.b_bus[1] = 8'hE7; i4.req = 4'b0010;
    tick();
    check("s1_gnt", i1.gnt, 4'b0001);
    check("s4_gnt", i4.gnt, 4'b0010);
    tick();
    check("s1_done", i1.done,  4'b0001);
    check("s1_y",    i1.y_out, 8'h42);
    check("s4_done_t1", i4.done, 0);
    i1.req = '0;
    tick();
    check("s1_idle", i1.busy, 0);
    check("s4_done_t2", i4.done, 0);
    tick();
    check("s4_done_t3", i4.done, 0);
    tick();
    check("s4_done", i4.done,  4'b0010);
    check("s4_y",    i4.y_out, 8'h24);
    i4.req = '0;
    tick();
    check("s4_idle", i4.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
